// File: rtl/ldpc_pkg.sv
// Shared encodings for the LDPC decoder: scheduler states seen by the check/variable
// node units and the top-level controller.
package ldpc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_VAR   = 2'd2,
    ST_DONE  = 2'd3
  } ldpc_state_e;

endpackage

// File: rtl/ldpc_addr_counter.sv
// Row/column address counter. It counts 0..LIMIT-1 and then returns to 0. The wrap flag
// marks the cycle that holds the last address while counting is enabled.
module ldpc_addr_counter #(
  parameter int W     = 3,
  parameter int LIMIT = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic at_last;

  assign at_last = (cnt == LAST);
  assign wrap    = en & at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ldpc_iter_scheduler.sv
// Start-gated, bounded LDPC iteration scheduler: check pass (m rows), then variable pass (n cols).
// Optional early termination on syndrome_ok is enabled by defining LDPC_EARLY_TERM_EN.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for start; iter_count/converged hold the last result
//  ST_CHECK | check-node pass, check_addr sweeps 0..m-1
//  ST_VAR   | variable-node pass, var_addr sweeps 0..n-1
//  ST_DONE  | one-cycle done pulse, then back to idle
module ldpc_iter_scheduler
  import ldpc_pkg::*;
#(
  parameter int log2m    = 3,
  parameter int m        = 6,
  parameter int log2n    = 4,
  parameter int n        = 12,
  parameter int log2iter = 3,
  parameter int MAX_ITER = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                syndrome_ok,
  output logic                check_en,
  output logic [log2m-1:0]    check_addr,
  output logic                var_en,
  output logic [log2n-1:0]    var_addr,
  output logic [1:0]          state,
  output logic [log2iter-1:0] iter_count,
  output logic                converged,
  output logic                done
);

`ifdef LDPC_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  // One extra bit so MAX_ITER == 2**log2iter is still detected.
  localparam logic [log2iter:0] ITER_LAST = (log2iter + 1)'(MAX_ITER);

  ldpc_state_e         state_q, state_d;
  logic [log2iter-1:0] iter_q, iter_d;
  logic                conv_q, conv_d;
  logic [log2iter:0]   iter_inc;
  logic                early_hit;
  logic                check_cnt_en, check_cnt_clr, check_wrap;
  logic                var_cnt_en, var_cnt_clr, var_wrap;

  // Counters run only inside their own phase, so they sit at 0 whenever a phase is entered.
  assign check_cnt_en  = (state_q == ST_CHECK) & ~abort;
  assign check_cnt_clr = (state_q != ST_CHECK) | abort;
  assign var_cnt_en    = (state_q == ST_VAR) & ~abort;
  assign var_cnt_clr   = (state_q != ST_VAR) | abort;

  ldpc_addr_counter #(
    .W     (log2m),
    .LIMIT (m)
  ) u_check_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (check_cnt_clr),
    .en    (check_cnt_en),
    .cnt   (check_addr),
    .wrap  (check_wrap)
  );

  ldpc_addr_counter #(
    .W     (log2n),
    .LIMIT (n)
  ) u_var_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (var_cnt_clr),
    .en    (var_cnt_en),
    .cnt   (var_addr),
    .wrap  (var_wrap)
  );

  assign iter_inc  = {1'b0, iter_q} + 1'b1;
  assign early_hit = EARLY_TERM & syndrome_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_CHECK;
          iter_d  = '0;
          conv_d  = 1'b0;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (check_wrap) begin
          if (early_hit) begin
            state_d = ST_DONE;
            conv_d  = 1'b1;
          end else begin
            state_d = ST_VAR;
          end
        end
      end
      ST_VAR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (var_wrap) begin
          iter_d  = iter_inc[log2iter-1:0];
          state_d = (iter_inc == ITER_LAST) ? ST_DONE : ST_CHECK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode flop state only; no input reaches an output combinationally.
  assign state      = state_q;
  assign check_en   = (state_q == ST_CHECK);
  assign var_en     = (state_q == ST_VAR);
  assign done       = (state_q == ST_DONE);
  assign iter_count = iter_q;
  assign converged  = conv_q;

endmodule

// File: tb/tb_ldpc_iter_scheduler.sv
// Self-checking bench for ldpc_iter_scheduler: a position-in-schedule reference model,
// directed scenarios with literal expectations, then randomized start/abort/syndrome traffic.
module tb_ldpc_iter_scheduler;

  localparam int M    = 6;
  localparam int N    = 12;
  localparam int MAXI = 4;
  localparam int L    = M + N;

`ifdef LDPC_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       syndrome_ok = 1'b0;
  logic       check_en;
  logic [2:0] check_addr;
  logic       var_en;
  logic [3:0] var_addr;
  logic [1:0] state;
  logic [2:0] iter_count;
  logic       converged;
  logic       done;

  int n_cmp = 0;
  int n_mis = 0;

  ldpc_iter_scheduler #(
    .log2m(3), .m(M), .log2n(4), .n(N), .log2iter(3), .MAX_ITER(MAXI)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .syndrome_ok (syndrome_ok),
    .check_en    (check_en),
    .check_addr  (check_addr),
    .var_en      (var_en),
    .var_addr    (var_addr),
    .state       (state),
    .iter_count  (iter_count),
    .converged   (converged),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_pos is the 1-based cycle index within a running decode; the phase and
  // addresses follow from (m_pos-1) mod (m+n), the iteration from the quotient.
  int m_pos  = 0;
  bit m_done = 1'b0;
  int m_iter = 0;
  bit m_conv = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int o, k;
    if (!rst_n) begin
      m_pos = 0; m_done = 1'b0; m_iter = 0; m_conv = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_pos == 0) begin
      if (start && !abort) begin
        m_pos = 1; m_iter = 0; m_conv = 1'b0;
      end
    end else if (abort) begin
      m_pos = 0;
    end else begin
      o = (m_pos - 1) % L;
      k = (m_pos - 1) / L;
      if (o == M - 1 && EARLY && syndrome_ok) begin
        m_done = 1'b1; m_pos = 0; m_conv = 1'b1; m_iter = k;
      end else if (o == L - 1) begin
        m_iter = k + 1;
        if (k + 1 == MAXI) begin
          m_done = 1'b1; m_pos = 0;
        end else begin
          m_pos++;
        end
      end else begin
        m_pos++;
      end
    end
  end

  always @(negedge clk) begin
    int o, es;
    o  = (m_pos > 0) ? (m_pos - 1) % L : 0;
    es = m_done ? 3 : (m_pos == 0) ? 0 : (o < M ? 1 : 2);
    chk("state", int'(state), es);
    chk("check_en", int'(check_en), int'(es == 1));
    chk("var_en", int'(var_en), int'(es == 2));
    chk("check_addr", int'(check_addr), (es == 1) ? o : 0);
    chk("var_addr", int'(var_addr), (es == 2) ? o - M : 0);
    chk("iter_count", int'(iter_count), m_iter);
    chk("converged", int'(converged), int'(m_conv));
    chk("done", int'(done), int'(m_done));
  end

  task automatic to_idle();
    @(negedge clk);
    start = 0; syndrome_ok = 0; abort = 1;
    @(negedge clk);
    abort = 0;
    @(negedge clk);
  endtask

  // start driven in cycle 0; inputs set at the negedge of cycle c apply to cycle c.
  task automatic run(input int mode, input int ncyc, output int done_cyc, output int ndone);
    @(negedge clk);
    start = 1; syndrome_ok = 0; abort = 0;
    done_cyc = -1;
    ndone = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      start = 0; syndrome_ok = 0; abort = 0;
      case (mode)
        1: syndrome_ok = (c == 24);
        2: syndrome_ok = (((c - 1) % L) != M - 1);
        3: start = (c == 10 || c == 40 || c == 74);
        4: begin
          abort = (c == 30);
          if (c == 35) begin start = 1; abort = 1; end
        end
        default: ;
      endcase
      if (mode == 0 && c == 6)  chk("lit_row5", int'(check_addr), 5);
      if (mode == 0 && c == 7)  chk("lit_var_start", int'(var_en), 1);
      if (mode == 0 && c == 18) chk("lit_col11", int'(var_addr), 11);
      if (mode == 0 && c == 19) chk("lit_iter2_check", int'(state), 1);
      if (mode == 3 && c == 75) chk("restart_state", int'(state), 1);
      if (mode == 3 && c == 75) chk("restart_addr", int'(check_addr), 0);
      if (mode == 4 && c == 31) chk("abort_idle", int'(state), 0);
      if (mode == 4 && c == 31) chk("abort_iter_held", int'(iter_count), 1);
      if (mode == 4 && c == 36) chk("start_abort_idle", int'(state), 0);
    end
  endtask

  initial begin
    int dc, nd;
    repeat (2) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_iter", int'(iter_count), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1;

    run(0, 80, dc, nd);
    chk("full_done_cycle", dc, 73);
    chk("full_done_count", nd, 1);
    chk("full_iter", int'(iter_count), 4);
    chk("full_conv", int'(converged), 0);
    to_idle();

    run(1, 80, dc, nd);
    chk("early_done_cycle", dc, EARLY ? 25 : 73);
    chk("early_iter", int'(iter_count), EARLY ? 1 : 4);
    chk("early_conv", int'(converged), EARLY ? 1 : 0);
    to_idle();

    run(2, 80, dc, nd);
    chk("offrow_done_cycle", dc, 73);
    chk("offrow_conv", int'(converged), 0);
    to_idle();

    run(3, 80, dc, nd);
    chk("restart_done_cycle", dc, 73);
    chk("restart_done_count", nd, 1);
    to_idle();

    run(4, 60, dc, nd);
    chk("abort_done_count", nd, 0);
    to_idle();

    // Asynchronous reset in cycle 10 (VAR pass of the first iteration).
    run(0, 10, dc, nd);
    #2 rst_n = 0;
    #1;
    chk("midrst_state", int'(state), 0);
    chk("midrst_check_addr", int'(check_addr), 0);
    chk("midrst_var_addr", int'(var_addr), 0);
    chk("midrst_check_en", int'(check_en), 0);
    chk("midrst_var_en", int'(var_en), 0);
    chk("midrst_iter", int'(iter_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    nd = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", nd, 0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start       = ($urandom_range(0, 3) == 0);
      abort       = ($urandom_range(0, 199) == 0);
      syndrome_ok = ($urandom_range(0, 9) == 0);
    end
    to_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
